// File: rtl/sort_pkg.sv
// Shared definitions for the counting-sorter front end: parser states and
// default key width / frame sync marker.
package sort_pkg;

  localparam int unsigned VALUE_WIDTH_DEF = 10;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned LEN_W           = 16;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_START,
    S_VAL_LO,
    S_VAL_HI,
    S_PUSH
  } parser_state_t;

endpackage

// File: rtl/sort_frame_parser.sv
// Turns framed UART bytes (sync, 16-bit LE length, LE 16-bit keys) into the
// counting sorter's start pulse, held length and key stream.
module sort_frame_parser
  import sort_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic                   sorter_busy_i,
  input  logic                   sorter_done_i,
  output logic                   start_o,
  output logic [LEN_W-1:0]       length_o,
  output logic [VALUE_WIDTH-1:0] value_o,
  output logic                   value_valid_o,
  input  logic                   value_ready_i,
  output logic                   range_err_o,
  output logic [7:0]             drop_cnt_o
);

  parser_state_t    state;
  logic [7:0]       len_lo;
  logic [7:0]       len_hi;
  logic [7:0]       val_lo;
  logic [LEN_W-1:0] remaining;

  logic             rx_fire_c;
  logic             push_fire_c;
  logic             start_ok_c;
  logic [LEN_W-1:0] len_word_c;
  logic [15:0]      val_word_c;

  assign rx_ready_o  = (state == S_SYNC)   || (state == S_LEN_LO) ||
                       (state == S_LEN_HI) || (state == S_VAL_LO) ||
                       (state == S_VAL_HI);
  assign rx_fire_c   = rx_valid_i && rx_ready_o;
  assign push_fire_c = value_valid_o && value_ready_i;
  // Sorter's done state (busy and done both high) is also a safe point to restart.
  assign start_ok_c  = !sorter_busy_i || sorter_done_i;
  assign len_word_c  = {len_hi, len_lo};
  assign val_word_c  = {rx_data_i, val_lo};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= S_SYNC;
      len_lo        <= 8'd0;
      len_hi        <= 8'd0;
      val_lo        <= 8'd0;
      remaining     <= '0;
      start_o       <= 1'b0;
      length_o      <= '0;
      value_o       <= '0;
      value_valid_o <= 1'b0;
      range_err_o   <= 1'b0;
      drop_cnt_o    <= 8'd0;
    end else begin
      start_o <= 1'b0;
      case (state)
        S_SYNC: begin
          if (rx_fire_c) begin
            if (rx_data_i == SYNC_BYTE) begin
              state <= S_LEN_LO;
            end else if (drop_cnt_o != 8'hFF) begin
              drop_cnt_o <= drop_cnt_o + 8'd1;
            end
          end
        end
        S_LEN_LO: begin
          if (rx_fire_c) begin
            len_lo <= rx_data_i;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_fire_c) begin
            len_hi <= rx_data_i;
            state  <= S_START;
          end
        end
        S_START: begin
          if (start_ok_c) begin
            length_o  <= len_word_c;
            start_o   <= 1'b1;
            remaining <= len_word_c;
            state     <= (len_word_c == '0) ? S_SYNC : S_VAL_LO;
          end
        end
        S_VAL_LO: begin
          if (rx_fire_c) begin
            val_lo <= rx_data_i;
            state  <= S_VAL_HI;
          end
        end
        S_VAL_HI: begin
          // Out-of-range keys are flagged but still forwarded truncated.
          if (rx_fire_c) begin
            value_o       <= val_word_c[VALUE_WIDTH-1:0];
            value_valid_o <= 1'b1;
            if ((val_word_c >> VALUE_WIDTH) != 16'd0) begin
              range_err_o <= 1'b1;
            end
            state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (push_fire_c) begin
            value_valid_o <= 1'b0;
            remaining     <= remaining - LEN_W'(1);
            state         <= (remaining == LEN_W'(1)) ? S_SYNC : S_VAL_LO;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule
